// File: rtl/alu_seq_slicer.sv
// Sequences a WIDTH-bit alu4 slice over NSLICE slices (LSB first) to build a WIDTH*NSLICE-bit operation.
// Latency NSLICE+1 enabled edges from accepted start to done; optional accumulate mode under ALU_SEQ_ACC_EN.
module alu_seq_slicer #(
  parameter int WIDTH    = 4,
  parameter int NSLICE   = 2,
  parameter int OP_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  input  logic [WIDTH*NSLICE-1:0]   opa,
  input  logic [WIDTH*NSLICE-1:0]   opb,
  input  logic                      cin,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic                      b_inv,
  input  logic                      b_zero,
`ifdef ALU_SEQ_ACC_EN
  input  logic                      acc_sel,
`endif
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  output logic                      alu_y,
  output logic [OP_WIDTH-1:0]       alu_op,
  output logic                      alu_b_inv,
  output logic                      alu_b_zero,
  input  logic [WIDTH-1:0]          alu_s,
  input  logic                      alu_c,
  input  logic                      alu_zero,
  input  logic                      alu_overflow,
  output logic [WIDTH*NSLICE-1:0]   result,
  output logic                      carry,
  output logic                      zero,
  output logic                      overflow,
  output logic                      busy,
  output logic                      done
);

  localparam int N  = WIDTH * NSLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [N-1:0]        opa_q, opb_q, result_q;
  logic [OP_WIDTH-1:0] op_q;
  logic                b_inv_q, b_zero_q;
  logic                creg_q, zacc_q, zero_q, ovf_q, done_q;
  logic                last_slice;

  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      b_inv_q  <= 1'b0;
      b_zero_q <= 1'b0;
      creg_q   <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef ALU_SEQ_ACC_EN
            // Accumulate: snapshot the previous result as operand A at capture time.
            opa_q <= acc_sel ? result_q : opa;
`else
            opa_q <= opa;
`endif
            opb_q    <= opb;
            op_q     <= op;
            b_inv_q  <= b_inv;
            b_zero_q <= b_zero;
            creg_q   <= cin;
            zacc_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          result_q[cnt_q*WIDTH +: WIDTH] <= alu_s;
          creg_q <= alu_c;
          zacc_q <= zacc_q & alu_zero;
          if (last_slice) begin
            ovf_q  <= alu_overflow;
            zero_q <= zacc_q & alu_zero;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    done_q <= 1'b0;
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign alu_a      = opa_q[cnt_q*WIDTH +: WIDTH];
  assign alu_b      = opb_q[cnt_q*WIDTH +: WIDTH];
  assign alu_y      = creg_q;
  assign alu_op     = op_q;
  assign alu_b_inv  = b_inv_q;
  assign alu_b_zero = b_zero_q;

  assign result   = result_q;
  assign carry    = creg_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_alu_seq_slicer.sv
// Scoreboard bench for alu_seq_slicer with a behavioural 4-bit ALU slice in the loop.
module tb_alu_seq_slicer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [7:0] opa = '0, opb = '0;
  logic       cin = 1'b0, b_inv = 1'b0, b_zero = 1'b0;
  logic [1:0] op = '0;
`ifdef ALU_SEQ_ACC_EN
  logic       acc_sel = 1'b0;
`endif
  logic [3:0] alu_a, alu_b, alu_s;
  logic       alu_y, alu_b_inv, alu_b_zero, alu_c, alu_zero, alu_overflow;
  logic [1:0] alu_op;
  logic [7:0] result;
  logic       carry, zero, overflow, busy, done;

  alu_seq_slicer #(.WIDTH(4), .NSLICE(2), .OP_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .opa(opa), .opb(opb), .cin(cin), .op(op), .b_inv(b_inv), .b_zero(b_zero),
`ifdef ALU_SEQ_ACC_EN
    .acc_sel(acc_sel),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_op(alu_op),
    .alu_b_inv(alu_b_inv), .alu_b_zero(alu_b_zero),
    .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .result(result), .carry(carry), .zero(zero), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ALU slice model: s = a + (b_zero ? 0 : b_inv ? ~b : b) + y
  logic [3:0] bb;
  logic [4:0] sum;
  always_comb begin
    bb  = alu_b_zero ? 4'h0 : (alu_b_inv ? ~alu_b : alu_b);
    sum = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_y};
  end
  assign alu_s        = sum[3:0];
  assign alu_c        = sum[4];
  assign alu_zero     = (sum[3:0] == 4'h0);
  assign alu_overflow = (alu_a[3] == bb[3]) && (sum[3] != alu_a[3]);

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every enabled cycle with done high consumes one expected response.
  always @(negedge clk) begin
    if (rst_n && ena && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with result %0h, expected no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("carry", carry, e.c);
        chk("zero", zero, e.z);
        chk("overflow", overflow, e.v);
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic inv, input logic zr, input logic acc,
                        input logic [7:0] er, input logic ec, input logic ez, input logic ev,
                        input int stall, input bit poke,
                        output int lat, output logic y0, output logic y1);
    int k;
    sb.push_back({er, ec, ez, ev});
    opa = a; opb = b; cin = ci; b_inv = inv; b_zero = zr;
`ifdef ALU_SEQ_ACC_EN
    acc_sel = acc;
`else
    if (acc) $display("note: accumulate requested but feature not built");
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    opa = ~a; opb = ~b; cin = ~ci; b_inv = ~inv; b_zero = ~zr;
    lat = 1; k = 0; y0 = 1'bx; y1 = 1'bx;
    while (!done && lat < 20) begin
      if (lat == 1 && stall > 0) begin
        ena = 1'b0;
        repeat (stall) tick();
        ena = 1'b1;
        lat += stall;
      end
      if (k == 0) y0 = alu_y;
      if (k == 1) y1 = alu_y;
      k++;
      if (poke && k == 1) start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
    end
    if (lat >= 20) chk("done_timeout", 32'(lat), 32'd3);
    tick();
    b_inv = 1'b0; b_zero = 1'b0; cin = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic y0, y1;
    rst_n = 1'b0; ena = 1'b1;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, overflow}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_y, alu_op, alu_b_inv, alu_b_zero}, 0);
    rst_n = 1'b1;
    tick();

    // 3C+0F: slice0 C+F=1B (carry 1), slice1 3+0+1=4
    run_op(8'h3C, 8'h0F, 0, 0, 0, 0, 8'h4B, 0, 0, 0, 0, 0, lat, y0, y1);
    chk("add_latency", 32'(lat), 3);
    chk("add_y0", y0, 0);
    chk("add_y1", y1, 1);

    // Reset during RUN clears everything at once.
    opa = 8'hFF; opb = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(8'hFF, 8'h01, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, lat, y0, y1);
    chk("wrap_latency", 32'(lat), 3);
    chk("wrap_y1", y1, 1);

    // Subtract: 10-01=0F, 80-01=7F with signed overflow in the top slice.
    run_op(8'h10, 8'h01, 1, 1, 0, 0, 8'h0F, 1, 0, 0, 0, 0, lat, y0, y1);
    chk("sub_y0", y0, 1);
    chk("sub_y1", y1, 0);
    run_op(8'h80, 8'h01, 1, 1, 0, 0, 8'h7F, 1, 0, 1, 0, 0, lat, y0, y1);

    // b_zero masks operand B entirely.
    run_op(8'h5A, 8'hFF, 0, 0, 1, 0, 8'h5A, 0, 0, 0, 0, 0, lat, y0, y1);

    // Two stall cycles in RUN plus a start pulse while busy.
    run_op(8'h3C, 8'h0F, 0, 0, 0, 0, 8'h4B, 0, 0, 0, 2, 1, lat, y0, y1);
    chk("stall_latency", 32'(lat), 5);
    repeat (6) tick();
    chk("idle_after_poke", busy, 0);

`ifdef ALU_SEQ_ACC_EN
    run_op(8'h3C, 8'h0F, 0, 0, 0, 0, 8'h4B, 0, 0, 0, 0, 0, lat, y0, y1);
    run_op(8'h00, 8'h05, 0, 0, 0, 1, 8'h50, 0, 0, 0, 0, 0, lat, y0, y1);
    acc_sel = 1'b0;
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
